// File: rtl/cmp16_sort_engine.sv
// In-place bubble sorter: loads DEPTH unsigned 16-bit words, sorts them with one
// time-shared comparator (one compare per cycle), then streams them out in ascending order.

module comparator_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        greater_than
);
  assign greater_than = (a > b);
endmodule

module cmp16_sort_engine #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_last,
  output logic        busy,
  output logic [7:0]  cmp_count
);

  localparam int DATA_W = 16;
  localparam int PW     = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
  localparam logic [PW-1:0] CMP_END  = PW'(DEPTH - 2);

  typedef enum logic [1:0] {S_LOAD, S_SORT, S_DRAIN} state_t;

  state_t            state, state_nxt;
  logic [PW-1:0]     wp, wp_nxt;
  logic [PW-1:0]     rp, rp_nxt;
  logic [PW-1:0]     idx, idx_nxt, idx_p1;
  logic              swapped, swapped_nxt;
  logic [7:0]        cmp_cnt, cmp_cnt_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              gt;
  logic              load_acc;
  logic              drain_acc;

  assign idx_p1    = idx + PW'(1);
  assign load_acc  = in_valid && (state == S_LOAD);
  assign drain_acc = out_ready && (state == S_DRAIN);

  comparator_16bit u_cmp (
    .a            (mem[idx]),
    .b            (mem[idx_p1]),
    .greater_than (gt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_LOAD;
      wp      <= '0;
      rp      <= '0;
      idx     <= '0;
      swapped <= 1'b0;
      cmp_cnt <= '0;
    end else begin
      state   <= state_nxt;
      wp      <= wp_nxt;
      rp      <= rp_nxt;
      idx     <= idx_nxt;
      swapped <= swapped_nxt;
      cmp_cnt <= cmp_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    wp_nxt      = wp;
    rp_nxt      = rp;
    idx_nxt     = idx;
    swapped_nxt = swapped;
    cmp_cnt_nxt = cmp_cnt;
    case (state)
      S_LOAD: begin
        if (load_acc) begin
          if (wp == LAST_IDX) begin
            state_nxt   = S_SORT;
            wp_nxt      = '0;
            idx_nxt     = '0;
            swapped_nxt = 1'b0;
            cmp_cnt_nxt = '0;
          end else begin
            wp_nxt = wp + PW'(1);
          end
        end
      end
      S_SORT: begin
        cmp_cnt_nxt = cmp_cnt + 8'd1;
        if (gt) swapped_nxt = 1'b1;
        if (idx != CMP_END) begin
          idx_nxt = idx_p1;
        end else if (swapped || gt) begin
          // A swap anywhere in this pass means another pass is needed
          idx_nxt     = '0;
          swapped_nxt = 1'b0;
        end else begin
          state_nxt = S_DRAIN;
          rp_nxt    = '0;
        end
      end
      S_DRAIN: begin
        if (drain_acc) begin
          if (rp == LAST_IDX) begin
            state_nxt = S_LOAD;
            rp_nxt    = '0;
            wp_nxt    = '0;
          end else begin
            rp_nxt = rp + PW'(1);
          end
        end
      end
      default: state_nxt = S_LOAD;
    endcase
  end

  // Buffer is data only: written on load accepts and on swaps, never reset
  always_ff @(posedge clk) begin
    if (load_acc) begin
      mem[wp] <= in_data;
    end else if ((state == S_SORT) && gt) begin
      mem[idx]    <= mem[idx_p1];
      mem[idx_p1] <= mem[idx];
    end
  end

  assign in_ready  = (state == S_LOAD);
  assign out_valid = (state == S_DRAIN);
  assign busy      = (state != S_LOAD);
  assign out_data  = (state == S_DRAIN) ? mem[rp] : '0;
  assign out_last  = (state == S_DRAIN) && (rp == LAST_IDX);
  assign cmp_count = cmp_cnt;

endmodule

// File: tb/tb_cmp16_sort_engine.sv
// Directed bench for cmp16_sort_engine (DEPTH=8): table-driven batches plus
// backpressure, reset-mid-sort and back-to-back sequences.

module tb_cmp16_sort_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;
  logic        busy;
  logic [7:0]  cmp_count;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [0:7][15:0] din;
    logic [0:7][15:0] dout;
    logic [7:0]       cmp;
  } vec_t;

  vec_t tbl [4];

  always #5 clk = ~clk;

  cmp16_sort_engine #(.DEPTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .cmp_count (cmp_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Presents 8 words back to back; optionally keeps in_valid high afterwards.
  task automatic load_batch(input logic [0:7][15:0] w, input bit hold);
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      in_data  = w[k];
      chk("in_ready_load", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
    end
    if (hold) in_data = 16'hDEAD;
    else      in_valid = 1'b0;
  endtask

  task automatic wait_sort(input logic [7:0] exp_cmp);
    int cyc = 0;
    chk("in_ready_sort", {31'd0, in_ready}, 32'd0);
    chk("busy_sort", {31'd0, busy}, 32'd1);
    chk("out_valid_sort", {31'd0, out_valid}, 32'd0);
    while (!out_valid && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("sort_cycles", cyc, {24'd0, exp_cmp});
    chk("cmp_count", {24'd0, cmp_count}, {24'd0, exp_cmp});
  endtask

  task automatic drain(input logic [0:7][15:0] exp, input bit bp);
    int idx = 0;
    int cyc = 0;
    bit done = 1'b0;
    while (!done && cyc < 200) begin
      out_ready = bp ? (cyc % 3 == 0) : 1'b1;
      chk("out_valid", {31'd0, out_valid}, 32'd1);
      chk("out_data", {16'd0, out_data}, {16'd0, exp[idx]});
      chk("out_last", {31'd0, out_last}, (idx == 7) ? 32'd1 : 32'd0);
      chk("in_ready_drain", {31'd0, in_ready}, 32'd0);
      if (out_ready) begin
        if (idx == 7) begin
          done     = 1'b1;
          in_valid = 1'b0;
        end
        idx++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b0;
    chk("drain_done", {31'd0, done}, 32'd1);
    chk("in_ready_after", {31'd0, in_ready}, 32'd1);
    chk("out_valid_after", {31'd0, out_valid}, 32'd0);
    chk("out_data_idle", {16'd0, out_data}, 32'd0);
    chk("out_last_idle", {31'd0, out_last}, 32'd0);
    chk("busy_after", {31'd0, busy}, 32'd0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {16'd0, out_data}, 32'd0);
    chk("rst_out_last", {31'd0, out_last}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_cmp_count", {24'd0, cmp_count}, 32'd0);
  endtask

  initial begin
    tbl[0].din  = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
    tbl[0].dout = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
    tbl[0].cmp  = 8'd7;
    tbl[1].din  = '{16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
    tbl[1].dout = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
    tbl[1].cmp  = 8'd56;
    tbl[2].din  = '{16'hFFFF, 16'h0000, 16'h0005, 16'h0005, 16'h8000, 16'h0000, 16'h0001, 16'hFFFF};
    tbl[2].dout = '{16'h0000, 16'h0000, 16'h0001, 16'h0005, 16'h0005, 16'h8000, 16'hFFFF, 16'hFFFF};
    tbl[2].cmp  = 8'd35;
    tbl[3].din  = '{16'd10, 16'd40, 16'd20, 16'd30, 16'd80, 16'd60, 16'd70, 16'd50};
    tbl[3].dout = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd50, 16'd60, 16'd70, 16'd80};
    tbl[3].cmp  = 8'd28;

    in_valid  = 1'b0;
    in_data   = 16'd0;
    out_ready = 1'b0;

    #2 rst = 1'b1;
    #1 chk_reset_outputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int t = 0; t < 3; t++) begin
      load_batch(tbl[t].din, 1'b0);
      wait_sort(tbl[t].cmp);
      drain(tbl[t].dout, 1'b0);
    end

    // Backpressure with in_valid held high through SORT and DRAIN
    load_batch(tbl[3].din, 1'b1);
    wait_sort(tbl[3].cmp);
    drain(tbl[3].dout, 1'b1);
    chk("cmp_count_hold_load", {24'd0, cmp_count}, 32'd28);

    // Reset in the middle of SORT after 10 compares
    load_batch(tbl[1].din, 1'b0);
    repeat (10) @(posedge clk);
    #1 chk("cmp_count_mid", {24'd0, cmp_count}, 32'd10);
    chk("busy_mid", {31'd0, busy}, 32'd1);
    #1 rst = 1'b1;
    #1 chk_reset_outputs();
    @(posedge clk); #1;
    rst = 1'b0;
    chk_reset_outputs();
    load_batch(tbl[0].din, 1'b0);
    wait_sort(tbl[0].cmp);
    drain(tbl[0].dout, 1'b0);

    // Back-to-back: second batch starts the cycle after out_last
    load_batch(tbl[2].din, 1'b0);
    wait_sort(tbl[2].cmp);
    drain(tbl[2].dout, 1'b0);
    chk("cmp_count_b2b_hold", {24'd0, cmp_count}, 32'd35);
    load_batch(tbl[1].din, 1'b0);
    wait_sort(tbl[1].cmp);
    drain(tbl[1].dout, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
